// File: rtl/cache_line_core.sv
// Direct-mapped, 8-set, 16-byte-line cache core with a zero-wait hit path,
// a write-back/fill miss sequence, and a line-granular physical-memory port.
module cache_line_core (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic         mem_resp,
    output logic [127:0] line_out,
    output logic [3:0]   cache_offset,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [7:0]     valid_r;
    logic [7:0]     dirty_r;
    logic [8:0]     tag_r  [8];
    logic [127:0]   data_r [8];

    logic [2:0]     index_s;
    logic [8:0]     tag_s;
    logic           req_s;
    logic           hit_s;
    logic           wr_hit_s;
    logic           wb_done_s;
    logic           fill_done_s;

    // Merge the enabled byte lanes of one 16-bit word into a line.
    function automatic logic [127:0] merge_word(
        input logic [127:0] line,
        input logic [2:0]   word,
        input logic [15:0]  wdata,
        input logic [1:0]   be
    );
        logic [127:0] res;
        res = line;
        res[{word, 4'b0000} +: 8] = be[0] ? wdata[7:0]  : line[{word, 4'b0000} +: 8];
        res[{word, 4'b1000} +: 8] = be[1] ? wdata[15:8] : line[{word, 4'b1000} +: 8];
        return res;
    endfunction

    assign index_s      = mem_address[6:4];
    assign tag_s        = mem_address[15:7];
    assign req_s        = mem_read | mem_write;
    assign hit_s        = valid_r[index_s] & (tag_r[index_s] == tag_s);
    assign wr_hit_s     = mem_resp & mem_write;
    assign wb_done_s    = reset_n & (state_r == WRITEBACK) & pmem_resp;
    assign fill_done_s  = reset_n & (state_r == FILL) & pmem_resp;
    assign line_out     = data_r[index_s];
    assign cache_offset = mem_address[3:0];

    // State register and per-set valid/dirty bits; these are the only reset state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
            valid_r <= 8'h00;
            dirty_r <= 8'h00;
        end else begin
            state_r <= state_next_s;
            if (wr_hit_s && (mem_byte_enable != 2'b00)) begin
                dirty_r[index_s] <= 1'b1;
            end else if (wb_done_s) begin
                dirty_r[index_s] <= 1'b0;
            end else if (fill_done_s) begin
                valid_r[index_s] <= 1'b1;
                dirty_r[index_s] <= 1'b0;
            end
        end
    end

    // Data and tag arrays; deliberately not reset so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_hit_s) begin
            data_r[index_s] <= merge_word(data_r[index_s], mem_address[3:1],
                                          mem_wdata, mem_byte_enable);
        end else if (fill_done_s) begin
            data_r[index_s] <= pmem_rdata;
            tag_r[index_s]  <= tag_s;
        end
    end

    // Next-state logic for the miss sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    state_next_s = dirty_r[index_s] ? WRITEBACK : FILL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITEBACK: state_next_s = pmem_resp ? FILL : WRITEBACK;
            FILL:      state_next_s = pmem_resp ? IDLE : FILL;
            default:   state_next_s = IDLE;
        endcase
    end

    // Output decode; everything is forced quiet while reset_n is low.
    always_comb begin
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        if (reset_n) begin
            case (state_r)
                IDLE: mem_resp = req_s & hit_s;
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_r[index_s], index_s, 4'h0};
                    pmem_wdata   = data_r[index_s];
                end
                FILL: begin
                    pmem_read    = 1'b1;
                    pmem_address = {mem_address[15:4], 4'h0};
                end
                default: mem_resp = 1'b0;
            endcase
        end else begin
            mem_resp = 1'b0;
        end
    end

endmodule

// File: tb/tb_cache_line_core.sv
// Directed plus randomized bench for cache_line_core against a set/line-level
// reference model and a sparse physical-memory model.
module tb_cache_line_core;

    logic         clk;
    logic         reset_n;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic         mem_resp;
    logic [127:0] line_out;
    logic [3:0]   cache_offset;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int total = 0;
    int bad   = 0;

    // Reference model: what each set holds, and what memory holds per line address.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_data  [8];
    logic [127:0] mem_m   [logic [11:0]];

    cache_line_core dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp),
        .line_out        (line_out),
        .cache_offset    (cache_offset),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] get_line(input logic [11:0] la);
        if (!mem_m.exists(la)) mem_m[la] = {$urandom, $urandom, $urandom, $urandom};
        return mem_m[la];
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // Apply a CPU write to the model: byte 2w gets the low lane, 2w+1 the high lane.
    function automatic void model_write(input logic [2:0] idx, input logic [2:0] w,
                                        input logic [15:0] wd, input logic [1:0] be);
        int base;
        base = 16 * int'(w);
        if (be[0]) m_data[idx][base +: 8]     = wd[7:0];
        if (be[1]) m_data[idx][base + 8 +: 8] = wd[15:8];
        if (be != 2'b00) m_dirty[idx] = 1'b1;
    endfunction

    // One CPU request; the bench plays memory with 'lat' wait cycles per transfer.
    // mode 0: normal, 1: drop request once FILL starts, 2: reset during FILL.
    task automatic access(input logic [15:0] a, input logic rd, input logic wr,
                          input logic [15:0] wd, input logic [1:0] be,
                          input int lat, input int mode);
        logic [2:0] idx;
        logic [8:0] tg;
        int         ph;
        int         waitc;
        bit         done;
        idx = a[6:4];
        tg  = a[15:7];
        mem_address = a; mem_read = rd; mem_write = wr;
        mem_wdata = wd; mem_byte_enable = be;
        ph = (m_valid[idx] && m_tag[idx] == tg) ? 3 : 0;
        waitc = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            chk("cache_offset", cache_offset, a[3:0]);
            case (ph)
                0: begin
                    chk("miss_resp", mem_resp, 1'b0);
                    chk("miss_idle_pmem", {pmem_read, pmem_write, pmem_address}, 18'h0);
                    ph = m_dirty[idx] ? 1 : 2;
                end
                1: begin
                    chk("wb_rw", {pmem_read, pmem_write, mem_resp}, 3'b010);
                    chk("wb_addr", pmem_address, {m_tag[idx], idx, 4'h0});
                    chk("wb_data", pmem_wdata, m_data[idx]);
                    if (waitc == lat) begin
                        pmem_resp = 1'b1;
                        mem_m[{m_tag[idx], idx}] = m_data[idx];
                        m_dirty[idx] = 1'b0;
                        ph = 2;
                        waitc = 0;
                    end else begin
                        waitc++;
                    end
                end
                2: begin
                    chk("fill_rw", {pmem_read, pmem_write, mem_resp}, 3'b100);
                    chk("fill_addr", pmem_address, {a[15:4], 4'h0});
                    if (mode == 1 && waitc == 0) begin
                        mem_read = 1'b0;
                        mem_write = 1'b0;
                    end
                    if (mode == 2) begin
                        reset_n = 1'b0;
                        ph = 4;
                    end else if (waitc == lat) begin
                        pmem_rdata = get_line(a[15:4]);
                        pmem_resp = 1'b1;
                        m_data[idx] = pmem_rdata;
                        m_tag[idx] = tg;
                        m_valid[idx] = 1'b1;
                        m_dirty[idx] = 1'b0;
                        ph = 3;
                    end else begin
                        waitc++;
                    end
                end
                3: begin
                    chk("idle_pmem", {pmem_read, pmem_write, pmem_address}, 18'h0);
                    if (mode == 1) begin
                        chk("dropped_resp", mem_resp, 1'b0);
                    end else begin
                        chk("hit_resp", mem_resp, 1'b1);
                        chk("hit_line", line_out, m_data[idx]);
                        if (wr) model_write(idx, a[3:1], wd, be);
                    end
                    done = 1'b1;
                end
                default: begin
                    chk("rst_quiet", {mem_resp, pmem_read, pmem_write, pmem_address}, 19'h0);
                    clear_model();
                    mem_read = 1'b0;
                    mem_write = 1'b0;
                    reset_n = 1'b1;
                    done = 1'b1;
                end
            endcase
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
        end
        if (!done) chk("access_timeout", 1'b0, 1'b1);
    endtask

    // Idle cycle with no request; optionally a stray pmem_resp that must be ignored.
    task automatic idle_cycle(input bit stray);
        mem_read = 1'b0;
        mem_write = 1'b0;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        pmem_resp = stray;
        #1;
        chk("idle_quiet", {mem_resp, pmem_read, pmem_write, pmem_address}, 19'h0);
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_address = 16'h1234; mem_read = 1'b1; mem_write = 1'b0;
        mem_wdata = 16'h0000; mem_byte_enable = 2'b00;
        pmem_rdata = 128'h0; pmem_resp = 1'b0;
        clear_model();
        mem_m[12'h123] = 128'h0000_0000_0000_0000_0000_0000_0000_0FEE;

        // Reset held with a request pending: everything stays quiet.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("reset_quiet", {mem_resp, pmem_read, pmem_write, pmem_address}, 19'h0);
        end
        reset_n = 1'b1;
        idle_cycle(1'b0);

        // Cold read, then byte-masked write hit, then inspect the bytes.
        access(16'h1234, 1'b1, 1'b0, 16'h0000, 2'b00, 3, 0);
        access(16'h1236, 1'b0, 1'b1, 16'hBEEF, 2'b10, 0, 0);
        mem_address = 16'h1236; mem_read = 1'b0; mem_write = 1'b0;
        #1;
        chk("byte7", line_out[63:56], 8'hBE);
        chk("byte6", line_out[55:48], 8'h00);
        chk("byte0", line_out[7:0], 8'hEE);
        @(posedge clk);
        #1;

        // Conflict miss on a dirty set, then a reset in the middle of FILL.
        access(16'h5230, 1'b1, 1'b0, 16'h0000, 2'b00, 2, 0);
        chk("wb_mem_byte7", mem_m[12'h123][63:56], 8'hBE);
        access(16'h1230, 1'b1, 1'b0, 16'h0000, 2'b00, 1, 2);
        idle_cycle(1'b0);
        access(16'h1230, 1'b1, 1'b0, 16'h0000, 2'b00, 1, 0);

        // Read and write together is a write.
        access(16'h1230, 1'b1, 1'b1, 16'hA5A5, 2'b11, 0, 0);
        mem_address = 16'h1230; mem_read = 1'b0;
        #1;
        chk("word0", line_out[15:0], 16'hA5A5);
        @(posedge clk);
        #1;

        // Request dropped mid-FILL still installs the line.
        access(16'h7230, 1'b1, 1'b0, 16'h0000, 2'b00, 0, 0);
        access(16'h1230, 1'b1, 1'b0, 16'h0000, 2'b00, 2, 1);
        idle_cycle(1'b0);
        access(16'h1230, 1'b1, 1'b0, 16'h0000, 2'b00, 0, 0);

        // Empty byte mask leaves the set clean; stray pmem_resp in IDLE is ignored.
        access(16'h1232, 1'b0, 1'b1, 16'h1111, 2'b00, 0, 0);
        access(16'h5230, 1'b1, 1'b0, 16'h0000, 2'b00, 1, 0);
        idle_cycle(1'b1);
        access(16'h5230, 1'b1, 1'b0, 16'h0000, 2'b00, 0, 0);

        // Randomized traffic over a small tag pool to force hits and conflicts.
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            logic        rd;
            logic        wr;
            a  = {7'h00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom)};
            rd = 1'($urandom);
            wr = !rd || ($urandom_range(0, 3) == 0);
            access(a, rd, wr, 16'($urandom), 2'($urandom), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 4) == 0) idle_cycle(1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
